// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key schedule and, later, the round datapath.
// Contents: round count, first round constant, key-schedule state enum,
// 32-bit word type and the GF(2^8) xtime helper.
package aes_pkg;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ks_state_t;

  typedef logic [31:0] word_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational table lookup.
// Ports:
//   din  - input byte
//   dout - substituted byte
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion. Accepts a cipher key and streams round
// keys 0..10 over a valid/ready interface, computing one round per accepted
// handshake.
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   key_valid/ready  - cipher key handshake (key_in[127:96] is w0)
//   round_key_valid/ready - round key handshake
//   round_key        - current round key (registered)
//   round_num        - index of round_key, 0..10
//   last             - round_key_valid and round_num == 10
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a cipher key, key_ready high
// ACTIVE | presenting round_key, advances on each round_key_ready
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         round_key_valid,
  input  logic         round_key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         last
);

  localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

  ks_state_t    state_q, state_d;
  logic [127:0] round_key_q;
  logic [3:0]   round_num_q;
  logic [7:0]   rcon_q;

  logic         key_accept;
  logic         advance;
  logic         final_accept;

  word_t        w0, w1, w2, w3;
  word_t        rot_w3, sub_w3, t_word;
  word_t        n0, n1, n2, n3;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_valid)    state_d = ACTIVE;
      ACTIVE:  if (final_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- output decode ----------------
  always_comb begin
    key_ready       = 1'b0;
    round_key_valid = 1'b0;
    case (state_q)
      IDLE:    key_ready       = 1'b1;
      ACTIVE:  round_key_valid = 1'b1;
      default: key_ready       = 1'b0;
    endcase
  end

  assign last      = round_key_valid && (round_num_q == LAST_ROUND);
  assign round_key = round_key_q;
  assign round_num = round_num_q;

  assign key_accept   = key_valid && key_ready;
  assign advance      = round_key_valid && round_key_ready && (round_num_q != LAST_ROUND);
  assign final_accept = round_key_ready && (round_num_q == LAST_ROUND);

  // ---------------- next round key ----------------
  assign w0 = round_key_q[127:96];
  assign w1 = round_key_q[95:64];
  assign w2 = round_key_q[63:32];
  assign w3 = round_key_q[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox3 (.din(rot_w3[31:24]), .dout(sub_w3[31:24]));
  aes_sbox u_sbox2 (.din(rot_w3[23:16]), .dout(sub_w3[23:16]));
  aes_sbox u_sbox1 (.din(rot_w3[15:8]),  .dout(sub_w3[15:8]));
  aes_sbox u_sbox0 (.din(rot_w3[7:0]),   .dout(sub_w3[7:0]));

  assign t_word = sub_w3 ^ {rcon_q, 24'h0};
  assign n0     = w0 ^ t_word;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  // ---------------- datapath registers ----------------
  // On the final handshake nothing here changes; the values are stale but
  // harmless because round_key_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_key_q <= 128'h0;
      round_num_q <= 4'd0;
      rcon_q      <= RCON_INIT;
    end else if (key_accept) begin
      round_key_q <= key_in;
      round_num_q <= 4'd0;
      rcon_q      <= RCON_INIT;
    end else if (advance) begin
      round_key_q <= {n0, n1, n2, n3};
      round_num_q <= round_num_q + 4'd1;
      rcon_q      <= xtime(rcon_q);
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         round_key_valid;
  logic         round_key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         last;

  int total = 0;
  int bad   = 0;

  logic [127:0] a1_tab [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  logic [127:0] zero_r1  = 128'h62636363626363636263636362636363;
  logic [127:0] zero_r10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  logic [127:0] other_key = 128'h000102030405060708090a0b0c0d0e0f;

  aes_key_schedule dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .key_valid       (key_valid),
    .key_ready       (key_ready),
    .key_in          (key_in),
    .round_key_valid (round_key_valid),
    .round_key_ready (round_key_ready),
    .round_key       (round_key),
    .round_num       (round_num),
    .last            (last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; round_key_ready = 1'b0;
    #2;
    total++;
    if (key_ready !== 1'b1 || round_key_valid !== 1'b0 || last !== 1'b0 ||
        round_key !== 128'h0 || round_num !== 4'd0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b last=%b rn=%0d rk=%h exp rdy=1 vld=0 last=0 rn=0 rk=0",
               key_ready, round_key_valid, last, round_num, round_key);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (key_ready !== 1'b1 || round_key_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b vld=%b exp rdy=1 vld=0", key_ready, round_key_valid);
    end
  endtask

  task automatic test_fips_a1();
    @(negedge clk);
    total++;
    if (key_ready !== 1'b1) begin
      bad++; $display("FAIL a1_idle_ready got=%b exp=1", key_ready);
    end
    key_valid = 1'b1; key_in = a1_tab[0]; round_key_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
      total++;
      if (round_key_valid !== 1'b1 || round_num !== 4'(k) || round_key !== a1_tab[k] ||
          last !== (k == 10) || key_ready !== 1'b0) begin
        bad++;
        $display("FAIL a1_round%0d got vld=%b rn=%0d rk=%h last=%b rdy=%b exp rk=%h",
                 k, round_key_valid, round_num, round_key, last, key_ready, a1_tab[k]);
      end
    end
    @(negedge clk);
    total++;
    if (round_key_valid !== 1'b0 || key_ready !== 1'b1 || last !== 1'b0) begin
      bad++;
      $display("FAIL a1_end got vld=%b rdy=%b last=%b exp vld=0 rdy=1 last=0",
               round_key_valid, key_ready, last);
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [127:0] prev_rk = '0;
    logic [3:0] prev_rn = '0;
    logic rdy;
    @(negedge clk);
    key_valid = 1'b1; key_in = a1_tab[0]; round_key_ready = 1'b0;
    while (idx < 11 && cyc < 300) begin
      @(negedge clk);
      key_valid = 1'b0;
      cyc++;
      if (prev_stall) begin
        total++;
        if (round_key_valid !== 1'b1 || round_key !== prev_rk || round_num !== prev_rn) begin
          bad++;
          $display("FAIL bp_stable got vld=%b rn=%0d rk=%h exp vld=1 rn=%0d rk=%h",
                   round_key_valid, round_num, round_key, prev_rn, prev_rk);
        end
      end
      rdy = 1'($urandom_range(0, 1));
      round_key_ready = rdy;
      if (round_key_valid && rdy) begin
        total++;
        if (round_key !== a1_tab[idx] || round_num !== 4'(idx)) begin
          bad++;
          $display("FAIL bp_key%0d got rn=%0d rk=%h exp rk=%h", idx, round_num, round_key, a1_tab[idx]);
        end
        idx++;
      end
      prev_stall = round_key_valid && !rdy;
      prev_rk    = round_key;
      prev_rn    = round_num;
    end
    total++;
    if (idx != 11) begin
      bad++; $display("FAIL bp_count got=%0d exp=11", idx);
    end
    @(negedge clk);
    round_key_ready = 1'b1;
    total++;
    if (round_key_valid !== 1'b0 || key_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_end got vld=%b rdy=%b exp vld=0 rdy=1", round_key_valid, key_ready);
    end
  endtask

  task automatic test_key_during_active();
    @(negedge clk);
    key_valid = 1'b1; key_in = a1_tab[0]; round_key_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      key_valid = (k == 5);
      key_in    = (k == 5) ? other_key : a1_tab[0];
      total++;
      if (round_key_valid !== 1'b1 || round_num !== 4'(k) || round_key !== a1_tab[k] || key_ready !== 1'b0) begin
        bad++;
        $display("FAIL kda_round%0d got vld=%b rn=%0d rk=%h rdy=%b exp rk=%h rdy=0",
                 k, round_key_valid, round_num, round_key, key_ready, a1_tab[k]);
      end
    end
    @(negedge clk);
    key_valid = 1'b0;
    total++;
    if (round_key_valid !== 1'b0 || key_ready !== 1'b1) begin
      bad++;
      $display("FAIL kda_end got vld=%b rdy=%b exp vld=0 rdy=1", round_key_valid, key_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    key_valid = 1'b1; key_in = a1_tab[0]; round_key_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
      total++;
      if (round_num !== 4'(k) || round_key !== a1_tab[k]) begin
        bad++;
        $display("FAIL rst_pre%0d got rn=%0d rk=%h exp rk=%h", k, round_num, round_key, a1_tab[k]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (round_key_valid !== 1'b0 || key_ready !== 1'b1 || round_key !== 128'h0 ||
        round_num !== 4'd0 || last !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got vld=%b rdy=%b rn=%0d rk=%h last=%b exp vld=0 rdy=1 rn=0 rk=0 last=0",
               round_key_valid, key_ready, round_num, round_key, last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    key_valid = 1'b1; key_in = a1_tab[0];
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      key_valid = 1'b0;
      total++;
      if (round_key_valid !== 1'b1 || round_num !== 4'(k) || round_key !== a1_tab[k]) begin
        bad++;
        $display("FAIL rst_post%0d got vld=%b rn=%0d rk=%h exp rk=%h",
                 k, round_key_valid, round_num, round_key, a1_tab[k]);
      end
    end
    @(negedge clk);
    total++;
    if (round_key_valid !== 1'b0 || key_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_end got vld=%b rdy=%b exp vld=0 rdy=1", round_key_valid, key_ready);
    end
  endtask

  task automatic test_back_to_back();
    int nkeys = 0;
    logic [127:0] exp_rk;
    @(negedge clk);
    key_valid = 1'b1; key_in = a1_tab[0]; round_key_ready = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      if (c == 1)  key_in = 128'h0;
      if (c == 13) key_valid = 1'b0;
      if (c <= 11) begin
        if (round_key_valid === 1'b1) nkeys++;
        total++;
        if (round_key_valid !== 1'b1 || round_num !== 4'(c - 1) || round_key !== a1_tab[c - 1]) begin
          bad++;
          $display("FAIL b2b_first%0d got vld=%b rn=%0d rk=%h exp rk=%h",
                   c - 1, round_key_valid, round_num, round_key, a1_tab[c - 1]);
        end
      end else if (c == 12) begin
        total++;
        if (round_key_valid !== 1'b0 || key_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_gap got vld=%b rdy=%b exp vld=0 rdy=1", round_key_valid, key_ready);
        end
      end else begin
        if (round_key_valid === 1'b1) nkeys++;
        total++;
        if (round_key_valid !== 1'b1 || round_num !== 4'(c - 13) || key_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_second%0d got vld=%b rn=%0d rdy=%b exp vld=1 rdy=0",
                   c - 13, round_key_valid, round_num, key_ready);
        end
        if (c == 13 || c == 14 || c == 23) begin
          exp_rk = (c == 13) ? 128'h0 : (c == 14) ? zero_r1 : zero_r10;
          total++;
          if (round_key !== exp_rk || last !== (c == 23)) begin
            bad++;
            $display("FAIL b2b_zero%0d got rk=%h last=%b exp rk=%h", c - 13, round_key, last, exp_rk);
          end
        end
      end
    end
    total++;
    if (nkeys != 22) begin
      bad++; $display("FAIL b2b_count got=%0d exp=22", nkeys);
    end
    @(negedge clk);
    total++;
    if (round_key_valid !== 1'b0 || key_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end got vld=%b rdy=%b exp vld=0 rdy=1", round_key_valid, key_ready);
    end
  endtask

  initial begin
    test_reset();
    test_fips_a1();
    test_backpressure();
    test_key_during_active();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative AES-128 key expansion engine that sits directly upstream of `add_round_key` in the encrypt datapath. It accepts a 128-bit cipher key and emits round keys 0 through 10 in order, one per accepted output handshake, on the `round_key` bus that `add_round_key` consumes. One new round key is computed per cycle, using four S-box lookups on the last word. No key storage beyond the current round key is kept.

## Interface
- Parameters: none. The block is AES-128 only; Nr = 10 and the 128-bit widths are fixed.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `key_valid` input 1: `key_in` is valid this cycle.
- `key_ready` output 1: engine is idle and can accept a key.
- `key_in` input 128: cipher key. `key_in[127:96]` is w0 (FIPS-197 byte order).
- `round_key_valid` output 1: `round_key` and `round_num` are valid.
- `round_key_ready` input 1: downstream accepts the current round key.
- `round_key` output 128: current round key, registered.
- `round_num` output 4: index of `round_key`, 0..10.
- `last` output 1: high while `round_num` == 10 and `round_key_valid` is high.

## Operation
- States are IDLE and ACTIVE.
- **IDLE**
  - `key_ready` = 1 and `round_key_valid` = 0.
  - A key handshake (`key_valid` & `key_ready`) loads `round_key` ← `key_in`, sets `round_num` ← 0 and `rcon` ← 8'h01, then goes to ACTIVE.
- **ACTIVE**
  - `key_ready` = 0 and `round_key_valid` = 1.
  - `key_valid` is ignored, and `key_in` is not sampled.
  - If `round_key_ready` = 0, hold all outputs stable (valid/ready rule: no retraction, no change while stalled).
  - If `round_key_ready` = 1 and `round_num` < 10:
    - `round_key` ← next key.
    - `round_num` ← `round_num`+1.
    - `rcon` ← xtime(`rcon`).
  - If `round_key_ready` = 1 and `round_num` == 10, go to IDLE. `round_key` and `round_num` keep their last values; they are don't-care with valid low.
- **Next key**, where w0..w3 are the 32-bit words of `round_key`, MSB-first:
  - t = SubWord(RotWord(w3)) ^ {`rcon`, 24'h0}, where RotWord(w) = {w[23:0], w[31:24]}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- **Rcon sequence** for rounds 1..10: 01 02 04 08 10 20 40 80 1B 36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00), taken mod 2^8.
- **Reset** (asynchronous assert, any state):
  - state = IDLE, `key_ready` = 1, `round_key_valid` = 0, `last` = 0.
  - `round_key` = 128'h0, `round_num` = 0, `rcon` = 8'h01.
  - Reset mid-expansion discards the sequence. No partial keys are emitted afterwards.

## Timing
- `key_ready` is a registered output, decoded from state.
- Key accepted at edge N: round key 0 is valid after edge N and presented in cycle N+1.
- With `round_key_ready` held high, round k is presented in cycle N+1+k. Round 10 is in cycle N+11.
- `key_ready` rises in cycle N+12. The next key can be accepted at the end of N+12.
- Throughput is one key per 12 cycles.
- Each cycle of `round_key_ready` = 0 adds exactly one cycle of stall. There is no skid or buffering.
- The next-key logic is combinational within one cycle: four S-box lookups plus an XOR chain.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_NR` = 10.
  - `RCON_INIT` = 8'h01.
  - The state enum (IDLE, ACTIVE).
  - The `xtime` function.
  - The word type (32-bit).
- Sub-module `aes_sbox`: combinational 8-bit in / 8-bit out forward S-box, instantiated four times for SubWord. It is reused later by SubBytes.

## Test plan
- **FIPS-197 A.1 key**
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, `round_key_ready`=1.
  - Round 0 equals the key.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `last`=1 in cycle N+11.
- **All-zero key**
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- **Random backpressure on `round_key_ready`**
  - Outputs are stable while stalled.
  - The same 11 keys appear in order, with no skip or duplicate.
- **Key during ACTIVE**
  - Pulse `key_valid` with a new key at round 5.
  - The sequence is unaffected and `key_ready` stays 0 until round 10 is accepted.
- **`rst_n` asserted at round 4**
  - Immediately: `round_key_valid`=0, `key_ready`=1, `round_key`=0.
  - A new key is accepted on the first cycle after deassert, and its round 0 appears one cycle later.
- **Back-to-back keys**
  - `key_valid` is held high with two keys.
  - The second key is accepted in cycle N+12.
  - 22 round keys are produced with no gaps other than the one-cycle IDLE.
